// File: rtl/wb_mux_ctrl.sv
// wb_mux_ctrl: Wishbone register block that drives the top_design_mux control
// pins. A select change is sequenced safely: every design is held in reset,
// the select moves, the configuration strobe pulses, reset is held again,
// and then the manual reset mask is restored.
module wb_mux_ctrl #(
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
  parameter int unsigned RESET_HOLD = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  o_mux_sel,
  output logic [7:0]  o_design_reset,
  output logic        o_mux_io5_reset_enb,
  output logic        o_mux_sys_reset_enb,
  output logic        o_mux_auto_reset_enb,
  output logic        o_conf_strobe,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, QUIESCE, SWITCH, RELEASE} state_t;

  localparam logic [7:0] HOLD       = 8'(RESET_HOLD);
  localparam logic [5:0] OFF_CTRL   = 6'd0;
  localparam logic [5:0] OFF_RESET  = 6'd1;
  localparam logic [5:0] OFF_STATUS = 6'd2;

  state_t      state_q, state_d;
  logic [7:0]  hold_cnt_q;
  logic [3:0]  ctrl_sel_q;
  logic [3:0]  sel_latch_q;
  logic [7:0]  reset_mask_q, reset_mask_d;
  logic [7:0]  switch_count_q;
  logic [31:0] rd_data;

  logic [3:0]  mux_sel_d;
  logic [7:0]  design_reset_d;
  logic        strobe_d;
  logic        busy_d;

  logic        in_window, accept;
  logic        wr_ctrl, wr_reset, sel_change, start_seq, direct_switch;

  // Address bits below the word offset and byte lanes above lane 0 carry no state.
  logic unused_inputs;
  assign unused_inputs = ^{wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:8]};

  assign in_window = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  // The !ack term limits a master that keeps stb high to one ack every two cycles.
  assign accept    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & in_window;
  assign wr_ctrl   = accept & wbs_we_i & (wbs_adr_i[7:2] == OFF_CTRL)  & wbs_sel_i[0];
  assign wr_reset  = accept & wbs_we_i & (wbs_adr_i[7:2] == OFF_RESET) & wbs_sel_i[0];

  // Only an idle CTRL write with a genuinely new select moves the mux; bit 6
  // of the written byte picks the sequenced path or the immediate path.
  assign sel_change    = wr_ctrl & (state_q == IDLE) & (wbs_dat_i[3:0] != o_mux_sel);
  assign start_seq     = sel_change &  wbs_dat_i[6];
  assign direct_switch = sel_change & ~wbs_dat_i[6];

  assign reset_mask_d = wr_reset ? wbs_dat_i[7:0] : reset_mask_q;

  // Register read mux, sampled on the accept cycle.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    rd_data = '0;
    unique case (wbs_adr_i[7:2])
      OFF_CTRL:   rd_data = {25'd0, o_mux_auto_reset_enb, o_mux_sys_reset_enb,
                             o_mux_io5_reset_enb, ctrl_sel_q};
      OFF_RESET:  rd_data = {24'd0, reset_mask_q};
      OFF_STATUS: rd_data = {8'd0, switch_count_q, 7'd0, o_busy, 4'd0, o_mux_sel};
      default:    rd_data = '0;
    endcase
  end

  // State register and reset-hold down-counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      hold_cnt_q <= 8'd0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if ((state_d == QUIESCE && state_q != QUIESCE) ||
          (state_d == RELEASE && state_q != RELEASE))
        hold_cnt_q <= HOLD;
      else if (hold_cnt_q != 8'd0)
        hold_cnt_q <= hold_cnt_q - 8'd1;
    end
  end

  // Next-state logic of the switch sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_seq)             state_d = QUIESCE;
      QUIESCE: if (hold_cnt_q == 8'd1)    state_d = SWITCH;
      SWITCH:                             state_d = RELEASE;
      RELEASE: if (hold_cnt_q == 8'd1)    state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Next values of the mux-facing outputs, derived from the upcoming state.
  always_comb begin
    mux_sel_d      = o_mux_sel;
    strobe_d       = 1'b0;
    busy_d         = (state_d != IDLE);
    design_reset_d = (state_d == IDLE) ? reset_mask_d : 8'hFF;
    if (direct_switch) begin
      mux_sel_d = wbs_dat_i[3:0];
      strobe_d  = 1'b1;
    end
    if (state_d == SWITCH) begin
      mux_sel_d = sel_latch_q;
      strobe_d  = 1'b1;
    end
  end

  // Bus handshake and software-visible registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o            <= 1'b0;
      wbs_dat_o            <= '0;
      ctrl_sel_q           <= 4'd0;
      sel_latch_q          <= 4'd0;
      reset_mask_q         <= 8'hFF;
      switch_count_q       <= 8'd0;
      o_mux_io5_reset_enb  <= 1'b1;
      o_mux_sys_reset_enb  <= 1'b1;
      o_mux_auto_reset_enb <= 1'b1;
    end else begin
      wbs_ack_o    <= accept;
      wbs_dat_o    <= (accept & ~wbs_we_i) ? rd_data : '0;
      reset_mask_q <= reset_mask_d;
      if (wr_ctrl) begin
        o_mux_io5_reset_enb  <= wbs_dat_i[4];
        o_mux_sys_reset_enb  <= wbs_dat_i[5];
        o_mux_auto_reset_enb <= wbs_dat_i[6];
        // A select written while a sequence runs is dropped.
        if (state_q == IDLE) ctrl_sel_q <= wbs_dat_i[3:0];
      end
      if (start_seq)          sel_latch_q    <= wbs_dat_i[3:0];
      if (state_d == SWITCH)  switch_count_q <= switch_count_q + 8'd1;
    end
  end

  // Registered mux-facing outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      o_mux_sel      <= 4'd0;
      o_design_reset <= 8'hFF;
      o_conf_strobe  <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_mux_sel      <= mux_sel_d;
      o_design_reset <= design_reset_d;
      o_conf_strobe  <= strobe_d;
      o_busy         <= busy_d;
    end
  end

endmodule

// File: doc/wb_mux_ctrl.md
# wb_mux_ctrl

Wishbone slave that owns the control inputs of `top_design_mux` as a register-driven alternative to the LA-driven controls. It sequences every design switch safely: all designs held in reset, select changed, configuration strobe pulsed, reset held again, then released. It sits between the Caravel Wishbone port of `user_project_wrapper` and the mux's control pins. The existing LA-versus-Wishbone arbitration stays outside this block.

## Interface
Parameters:
- `ADDR_BASE`, default 32'h3000_0000: register window base; bits [31:8] are decoded.
- `RESET_HOLD`, default 16: cycles of forced reset before and after a select change; legal range 1..255.

Ports:
- `wb_clk_i` input 1: single clock.
- `wb_rst_i` input 1: reset, synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input 1 each: Wishbone strobe, cycle and write enable.
- `wbs_sel_i` input 4: byte-lane enables for writes.
- `wbs_adr_i` input 32: byte address.
- `wbs_dat_i` input 32: write data.
- `wbs_ack_o` output 1: single-cycle acknowledge.
- `wbs_dat_o` output 32: read data, valid while ack is high, 0 otherwise.
- `o_mux_sel` output 4: drives `i_mux_sel`.
- `o_design_reset` output 8: drives `i_design_reset`.
- `o_mux_io5_reset_enb`, `o_mux_sys_reset_enb`, `o_mux_auto_reset_enb` output 1 each: drive the matching mux inputs.
- `o_conf_strobe` output 1: one-cycle pulse that replaces `mux_conf_clk`.
- `o_busy` output 1: high while a switch sequence is running.

## Operation
Registers (offset = `wbs_adr_i[7:2]`):
- 0x00 CTRL, R/W.
  - [3:0] `sel_req`.
  - [4] io5_reset_enb.
  - [5] sys_reset_enb.
  - [6] auto_reset_enb.
  - Other bits read as 0.
- 0x04 RESET, R/W.
  - [7:0] manual design reset mask.
- 0x08 STATUS, read-only.
  - [3:0] current `o_mux_sel`.
  - [8] busy.
  - [23:16] switch_count.
  - Writes are ignored.

Register rules:
- Writes honour `wbs_sel_i` per byte lane.
- Unmapped offsets inside the window: ack, read 0, writes ignored.
- Addresses outside the window (`wbs_adr_i[31:8] != ADDR_BASE[31:8]`): never acked.

Wishbone handshake:
- A request is accepted on any cycle with `stb & cyc & !wbs_ack_o`.
- Ack rises the following cycle for exactly one cycle.
- A master holding stb gets one ack every two cycles.

Switch FSM, states IDLE, QUIESCE, SWITCH, RELEASE:
- IDLE:
  - A CTRL write whose `sel_req` byte is written with a value different from current `o_mux_sel`, with auto_reset_enb = 1 after the write, moves to QUIESCE and latches `sel_req`.
  - With auto_reset_enb = 0, `o_mux_sel` updates on the ack cycle, `o_conf_strobe` pulses on that same cycle, and no reset is forced.
- QUIESCE: `o_design_reset` = 8'hFF for RESET_HOLD cycles, counted by an 8-bit down-counter.
- SWITCH: lasts one cycle.
  - `o_mux_sel` = latched value.
  - `o_conf_strobe` = 1.
  - `o_design_reset` = 8'hFF.
  - switch_count increments, wrapping 255 -> 0.
- RELEASE: `o_design_reset` = 8'hFF for RESET_HOLD cycles, then return to IDLE.
- IDLE output: `o_design_reset` = RESET register.

Boundary rules:
- A CTRL write while busy updates bits [6:4] and is acked normally; its `sel_req` field is discarded.
- A write of the same select value starts no sequence.
- A RESET register write while busy is stored and takes effect on return to IDLE.
- auto_reset_enb cleared mid-sequence does not abort the sequence.
- `o_busy` = 1 in QUIESCE, SWITCH and RELEASE.

## Timing
Reset values (`wb_rst_i` high on an edge):
- `o_mux_sel` = 0.
- `o_design_reset` = 8'hFF; RESET register = 8'hFF.
- The three enb outputs = 1.
- `wbs_ack_o` = 0, `wbs_dat_o` = 0.
- `o_conf_strobe` = 0, `o_busy` = 0.
- switch_count = 0.
- FSM = IDLE.
- Reset mid-sequence aborts immediately to these values.

All outputs are registered.

Sequence timing: with a write accepted at cycle 0:
- Ack at cycle 1.
- QUIESCE covers cycles 1..RESET_HOLD.
- SWITCH at cycle RESET_HOLD+1.
- RELEASE covers cycles RESET_HOLD+2..2·RESET_HOLD+1.
- IDLE, with `o_busy` = 0 and manual reset restored, at cycle 2·RESET_HOLD+2.

Read data is sampled on the accept cycle and presented with the ack.

## Test plan
- Reset, then read 0x00, 0x04 and 0x08 -> 0x70, 0xFF and 0x0 respectively; `o_design_reset` = 8'hFF.
- Write 0x04 = 0x00, then CTRL = 0x73, RESET_HOLD = 16, write accepted at cycle 0:
  - ack at cycle 1;
  - `o_design_reset` = 0xFF during cycles 1..33;
  - `o_mux_sel` = 3 and strobe high at cycle 17 only;
  - `o_busy` falls and `o_design_reset` = 0x00 at cycle 34;
  - STATUS = 0x0001_0003.
- Write CTRL = 0x05 (auto off) -> `o_mux_sel` = 5 and strobe on the ack cycle, `o_design_reset` unchanged, `o_busy` never high.
- During a sequence:
  - write CTRL sel = 9 -> acked; final `o_mux_sel` is the original request;
  - write RESET = 0x0F -> 0x0F appears only after IDLE.
- Assert `wb_rst_i` at cycle 10 of a sequence -> all outputs at reset values on the next cycle, `o_conf_strobe` never pulses.
- Bus edge cases:
  - read of offset 0x3C -> ack with 0;
  - access at ADDR_BASE+0x100 -> no ack for 20 cycles;
  - write with `wbs_sel_i` = 4'b0010 to CTRL -> sel unchanged;
  - 256 completed switches -> switch_count = 0.
